// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state type and width helper for the bit-serial subtractor
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - combinational one-bit full subtractor
module full_subtractor_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // difference and borrow for a - b - bin
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor d = x - y, optional ovf under SERIAL_SUB_OVF_EN
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int n = 4,
   parameter int m = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [n-1:0] x,
   input  logic [m-1:0] y,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] d,
   output logic         bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int cw = clog2(n) + 1;

   state_t          state;
   logic [n-1:0]    a;
   logic [n-1:0]    b;
   logic [n-1:0]    res;
   logic            br;
   logic [cw-1:0]   cnt;
   logic [n-1:0]    y_ext;
   logic            di;
   logic            br_next;
   logic [n-1:0]    res_next;

`ifdef SERIAL_SUB_OVF_EN
   logic            a_msb;
   logic            b_msb;
`endif

   // zero-extend the subtrahend to the operand width
   always_comb begin
      y_ext        = '0;
      y_ext[m-1:0] = y;
   end

   // result register after inserting this cycle's difference bit at the MSB
   always_comb begin
      res_next = {di, res[n-1:1]};
   end

   full_subtractor_bit u_bit (
      .a    (a[0]),
      .b    (b[0]),
      .bin  (br),
      .d    (di),
      .bout (br_next)
   );

   // control FSM and serial datapath; d/bout only change on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         bout  <= 1'b0;
         a     <= '0;
         b     <= '0;
         res   <= '0;
         br    <= 1'b0;
         cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
         ovf   <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a     <= x;
                  b     <= y_ext;
                  res   <= '0;
                  br    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= BUSY;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb <= x[n-1];
                  b_msb <= y_ext[n-1];
`endif
               end
            end
            BUSY: begin
               res <= res_next;
               a   <= {1'b0, a[n-1:1]};
               b   <= {1'b0, b[n-1:1]};
               br  <= br_next;
               cnt <= cnt + 1'b1;
               if (cnt == cw'(n - 1)) begin
                  d     <= res_next;
                  bout  <= br_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                  ovf   <= (a_msb != b_msb) && (di != a_msb);
`endif
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

   localparam int N = 4;
   localparam int M = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] x;
   logic [M-1:0] y;
   logic         busy;
   logic         done;
   logic [N-1:0] d;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
   logic         last_ovf;
`endif

   int checks = 0;
   int errors = 0;

   logic [N-1:0] last_d;
   logic         last_bout;

   always #5 clk = ~clk;

   serial_subtractor #(.n(N), .m(M)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .y     (y),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference: unsigned modular difference and borrow
   function automatic logic [N-1:0] ref_d(input int xv, input int yv);
      return N'((xv + (1 << N) - yv) % (1 << N));
   endfunction

   function automatic logic ref_bout(input int xv, input int yv);
      return xv < yv;
   endfunction

   // reference: signed overflow of the N-bit operands
   function automatic logic ref_ovf(input int xv, input int yv);
      int sx, sy, r;
      sx = (xv >= (1 << (N-1))) ? xv - (1 << N) : xv;
      sy = (yv >= (1 << (N-1))) ? yv - (1 << N) : yv;
      r  = sx - sy;
      return (r > (1 << (N-1)) - 1) || (r < -(1 << (N-1)));
   endfunction

   // one operation from IDLE; optional ignored start in BUSY cycle glitch_at; optional input scrambling
   task automatic do_op(input int xv, input int yv, input int glitch_at, input bit scramble);
      x = N'(xv);
      y = M'(yv);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= N; i++) begin
         check("busy_in_op", busy, 1'b1);
         check("no_done_in_op", done, 1'b0);
         check("d_held_in_op", d, last_d);
         check("bout_held_in_op", bout, last_bout);
         if (i == glitch_at) begin
            start = 1'b1;
            x = '0;
            y = '1;
         end
         if (scramble) begin
            x = N'($urandom);
            y = M'($urandom);
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      last_d    = ref_d(xv, yv);
      last_bout = ref_bout(xv, yv);
      check("done_pulse", done, 1'b1);
      check("busy_off_done", busy, 1'b0);
      check("d_result", d, last_d);
      check("bout_result", bout, last_bout);
`ifdef SERIAL_SUB_OVF_EN
      last_ovf = ref_ovf(xv, yv);
      check("ovf_result", ovf, last_ovf);
`endif
      @(posedge clk); #1;
      check("done_single_cycle", done, 1'b0);
      check("idle_busy_low", busy, 1'b0);
      check("d_hold_after", d, last_d);
   endtask

   initial begin
      int cyc;
      rst = 1'b1;
      start = 1'b0;
      x = '0;
      y = '0;
      last_d = '0;
      last_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      last_ovf = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_d", d, '0);
      check("rst_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", ovf, 1'b0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // directed cases
      do_op(4'b0011, 4'b0001, 0, 1'b0);
      do_op(4'b0001, 4'b0010, 0, 1'b0);
      do_op(4'b0000, 4'b0000, 0, 1'b0);
      do_op(4'b1111, 4'b1110, 0, 1'b0);
      do_op(4'b1111, 4'b1111, 0, 1'b0);
      do_op(4'b0000, 4'b1111, 0, 1'b0);
      do_op(4'b0100, 4'b0011, 2, 1'b0);

      // abort by reset on the 2nd BUSY edge
      x = 4'b1010;
      y = 4'b0101;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("abort_busy_pre", busy, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_d", d, '0);
      check("abort_bout", bout, 1'b0);
      last_d = '0;
      last_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      last_ovf = 1'b0;
`endif
      for (int i = 0; i < 6; i++) begin
         check("abort_no_done", done, 1'b0);
         @(posedge clk); #1;
      end
      do_op(4'b0110, 4'b0010, 0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
      do_op(4'b1000, 4'b0001, 0, 1'b0);
      do_op(4'b0101, 4'b0011, 0, 1'b0);
      do_op(4'b0111, 4'b1111, 0, 1'b0);
`endif

      // start held high: back-to-back with one IDLE cycle between done and reload
      x = 4'b1001;
      y = 4'b0100;
      start = 1'b1;
      cyc = 0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("b2b_first_done_seen", done, 1'b1);
      check("b2b_first_latency", cyc, N + 1);
      check("b2b_first_d", d, ref_d(9, 4));
      @(posedge clk); #1;
      check("b2b_idle_gap_busy", busy, 1'b0);
      check("b2b_idle_gap_done", done, 1'b0);
      @(posedge clk); #1;
      check("b2b_reload_busy", busy, 1'b1);
      start = 1'b0;
      x = 4'b0010;
      y = 4'b0111;
      cyc = 0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("b2b_second_done_seen", done, 1'b1);
      check("b2b_second_d", d, ref_d(9, 4));
      check("b2b_second_bout", bout, ref_bout(9, 4));
      last_d = ref_d(9, 4);
      last_bout = ref_bout(9, 4);
`ifdef SERIAL_SUB_OVF_EN
      last_ovf = ref_ovf(9, 4);
`endif
      @(posedge clk); #1;
      check("b2b_end_done_low", done, 1'b0);

      // randomized operations with inputs scrambled while busy
      for (int k = 0; k < 40; k++) begin
         do_op(int'($urandom_range(0, (1 << N) - 1)), int'($urandom_range(0, (1 << M) - 1)),
               int'($urandom_range(0, N)), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
